// File: rtl/drive_command_arbiter_if.sv
// Request and command bundle shared by the IR, camera and microphone requesters,
// the drive arbiter (slave) and whoever drives/observes it (master).
interface drive_command_arbiter_if;
    logic       ir_valid;
    logic [2:0] ir_cmd;
    logic       cam_valid;
    logic [2:0] cam_direction;
    logic       orange_detected;
    logic [1:0] speed;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_dir;
    logic [1:0] cmd_speed;
    logic [1:0] mode;

    modport slave (
        input  ir_valid, ir_cmd, cam_valid, cam_direction, orange_detected, speed, cmd_ready,
        output cmd_valid, cmd_dir, cmd_speed, mode
    );

    modport master (
        output ir_valid, ir_cmd, cam_valid, cam_direction, orange_detected, speed, cmd_ready,
        input  cmd_valid, cmd_dir, cmd_speed, mode
    );
endinterface

// File: rtl/drive_command_arbiter.sv
// Drive-mode arbiter: picks manual/search/track behaviour from IR and camera events
// and offers one drive command at a time to the motor serializer.
//
// state    | meaning
// S_IDLE   | motors stopped, waiting for an IR command
// S_MANUAL | driving the last IR direction until hold time runs out
// S_SEARCH | spinning right at fixed speed looking for the target
// S_TRACK  | steering toward the camera-reported target direction
module drive_command_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 50_000_000,
    parameter int unsigned LOST_FRAMES  = 15,
    parameter logic [1:0]  SEARCH_SPEED = 2'd1
) (
    input logic                    clk_50,
    input logic                    rst_n,
    drive_command_arbiter_if.slave bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LW = $clog2(LOST_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LOST_MAX  = LW'(LOST_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MANUAL = 2'd1,
        S_SEARCH = 2'd2,
        S_TRACK  = 2'd3
    } state_t;

    state_t        state_q;
    logic [2:0]    ir_dir_q;
    logic [2:0]    cam_dir_q;
    logic [HW-1:0] hold_q;
    logic [LW-1:0] lost_q;
    logic          cmd_valid_q;
    logic [2:0]    cmd_dir_q;
    logic [1:0]    cmd_speed_q;
    logic [2:0]    last_dir_q;
    logic [1:0]    last_speed_q;

    logic          ir_ev;
    logic          cam_ev;
    logic [2:0]    cam_dir_n;
    logic [LW-1:0] lost_inc;
    logic [2:0]    des_dir;
    logic [1:0]    des_speed;

    // Reserved IR codes are dropped entirely, so they do not mask a camera frame.
    assign ir_ev     = bus.ir_valid && (bus.ir_cmd <= 3'd5);
    assign cam_ev    = bus.cam_valid && !ir_ev;
    assign cam_dir_n = (bus.cam_direction > 3'd4) ? 3'd0 : bus.cam_direction;
    assign lost_inc  = (lost_q == LOST_MAX) ? lost_q : lost_q + LW'(1);

    always_comb begin
        des_dir   = 3'd0;
        des_speed = 2'd0;
        case (state_q)
            S_MANUAL: begin
                des_dir   = ir_dir_q;
                des_speed = bus.speed;
            end
            S_SEARCH: begin
                des_dir   = 3'd4;
                des_speed = SEARCH_SPEED;
            end
            S_TRACK: begin
                des_dir   = cam_dir_q;
                des_speed = bus.speed;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ir_dir_q     <= 3'd0;
            cam_dir_q    <= 3'd0;
            hold_q       <= '0;
            lost_q       <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_dir_q    <= 3'd0;
            cmd_speed_q  <= 2'd0;
            last_dir_q   <= 3'd0;
            last_speed_q <= 2'd0;
        end else begin
            if (ir_ev) begin
                case (bus.ir_cmd)
                    3'd0: state_q <= S_IDLE;
                    3'd5: begin
                        if (state_q == S_IDLE || state_q == S_MANUAL) state_q <= S_SEARCH;
                    end
                    default: begin
                        state_q  <= S_MANUAL;
                        ir_dir_q <= bus.ir_cmd;
                        hold_q   <= HOLD_LOAD;
                    end
                endcase
            end else if (state_q == S_MANUAL) begin
                if (hold_q == '0) state_q <= S_IDLE;
                else              hold_q  <= hold_q - HW'(1);
            end else if (cam_ev && bus.orange_detected &&
                         (state_q == S_SEARCH || state_q == S_TRACK)) begin
                state_q   <= S_TRACK;
                cam_dir_q <= cam_dir_n;
                lost_q    <= '0;
            end else if (cam_ev && state_q == S_TRACK) begin
                lost_q <= lost_inc;
                if (lost_inc == LOST_MAX) state_q <= S_SEARCH;
            end

            // Offer is frozen while pending; a fresh desired value waits one idle cycle.
            if (cmd_valid_q) begin
                if (bus.cmd_ready) begin
                    cmd_valid_q  <= 1'b0;
                    last_dir_q   <= cmd_dir_q;
                    last_speed_q <= cmd_speed_q;
                end
            end else if ({des_dir, des_speed} != {last_dir_q, last_speed_q}) begin
                cmd_valid_q <= 1'b1;
                cmd_dir_q   <= des_dir;
                cmd_speed_q <= des_speed;
            end
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_dir   = cmd_dir_q;
    assign bus.cmd_speed = cmd_speed_q;
    assign bus.mode      = state_q;
endmodule

// File: doc/drive_command_arbiter.md
# drive_command_arbiter

Arbitrates robot drive control between three requesters: IR remote (manual), camera target tracking (auto), and microphone speed level. It owns the mode state machine (IDLE, MANUAL, SEARCH, TRACK) and issues one drive command at a time to the motor-command serializer over a valid/ready handshake. It sits in the `clk_50` domain between `IR_top_level`, `classification`, `mic_top_level` and the motor output path.

## Interface
- `HOLD_CYCLES`, default 50_000_000: manual-command hold time without a new IR command (1 s at 50 MHz).
- `LOST_FRAMES`, default 15: consecutive camera frames without the target before leaving TRACK.
- `SEARCH_SPEED`, default 2'd1: fixed speed used in SEARCH.
- `clk_50  in  1`: system clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `ir_valid  in  1`: one-cycle pulse; `ir_cmd` is valid.
- `ir_cmd  in  3`: 0 stop, 1 forward, 2 back, 3 left, 4 right, 5 auto, 6–7 reserved.
- `cam_valid  in  1`: one-cycle pulse per camera frame result.
- `cam_direction  in  3`: direction code 0–4, same encoding as `ir_cmd`.
- `orange_detected  in  1`: target present in the frame; sampled only with `cam_valid`.
- `speed  in  2`: microphone speed level.
- `cmd_valid  out  1`: a drive command is offered.
- `cmd_ready  in  1`: downstream accepts the command.
- `cmd_dir  out  3`: offered direction code.
- `cmd_speed  out  2`: offered speed.
- `mode  out  2`: 0 IDLE, 1 MANUAL, 2 SEARCH, 3 TRACK.

## Operation
- **Reset values:** `mode` = IDLE. `cmd_valid` = 0. `cmd_dir` = 0. `cmd_speed` = 0. Hold counter and lost counter = 0. Last-sent register = {dir 0, speed 0}.
- **Ignored inputs:** `ir_valid` with a reserved code is ignored. `cam_direction` greater than 4 is treated as 0.
- **IDLE:** desired output is {0, 0}.
  - IR 1–4 → MANUAL.
  - IR 5 → SEARCH.
- **MANUAL:** desired output is {latched IR code, `speed`}.
  - Each IR 1–4 relatches the code and reloads the hold counter to `HOLD_CYCLES`-1.
  - Counter reaches 0 → IDLE.
  - IR 0 → IDLE.
  - IR 5 → SEARCH.
- **SEARCH:** desired output is {4 (right), `SEARCH_SPEED`}.
  - `cam_valid` with `orange_detected`=1 → TRACK; lost counter cleared.
  - IR 0 → IDLE.
  - IR 1–4 → MANUAL.
- **TRACK:** desired output is {latched `cam_direction`, `speed`}. The direction latches on each `cam_valid` with detection.
  - `cam_valid` with detection=0 increments the lost counter.
  - `cam_valid` with detection=1 clears the lost counter.
  - Lost counter reaching `LOST_FRAMES` → SEARCH.
  - IR 0 → IDLE.
  - IR 1–4 → MANUAL.
  - IR 5 → no change.
- **Priority:** `ir_valid` and `cam_valid` in the same cycle: IR wins, and the camera event is discarded that cycle.
- **Command issue:**
  - When `cmd_valid`=0 and desired ≠ last-sent, register desired into `cmd_dir`/`cmd_speed` and assert `cmd_valid`.
  - While `cmd_valid`=1 and `cmd_ready`=0, `cmd_dir`/`cmd_speed` are held stable regardless of desired changes.
  - Transfer occurs on a cycle with `cmd_valid`&&`cmd_ready`: last-sent is updated and `cmd_valid` drops next edge. Any newer desired value is offered on the following evaluation (minimum one idle cycle between commands).
  - An unchanged desired value never produces a command.
- **Counter widths:** hold counter is `$clog2(HOLD_CYCLES)` bits; lost counter is `$clog2(LOST_FRAMES+1)` bits and saturates.
- **Reset mid-operation:** asynchronous reset takes effect immediately. A pending command is dropped and is not reissued unless desired differs from {0, 0}.

## Timing
- `ir_valid`/`cam_valid` sampled at edge N → `mode` updated after N → `cmd_valid` high after edge N+1 (2-edge latency), provided no command is pending.
- Hold expiry: last IR 1–4 at edge N → `mode`=IDLE after edge N+`HOLD_CYCLES`.
- `cmd_ready` may be tied high. Then each command lasts exactly one cycle, and commands are at most one every 2 cycles.
- `cmd_ready` has no combinational path to any output.

## Test plan
- **Reset and manual:** reset, then IR 1 with `speed`=2 → `mode`=1; `cmd_valid` rises 2 edges later with {1, 2}; `cmd_ready`=1 → one-cycle pulse, and no repeat while inputs are static.
- **Hold expiry** (`HOLD_CYCLES`=20): IR 3, no further IR → `mode` returns to 0 after 20 edges and command {0, 0} is issued. With IR 3 re-sent at cycle 15, IDLE is reached at cycle 35.
- **Search/track/lost** (`LOST_FRAMES`=3): IR 5 → {4, 1}. Then `cam_valid`+detect, dir 3 → TRACK {3, `speed`}. Three `cam_valid` without detection → SEARCH {4, 1}. Two misses then one hit keeps TRACK.
- **Backpressure:** `cmd_ready`=0 while desired changes 1 → 2 → 4 → `cmd_dir` stays 1 throughout; after `cmd_ready`=1 for one cycle, `cmd_valid` drops, then {4, x} is offered; 2 is never sent.
- **Collision:** `ir_valid` cmd 0 and `cam_valid`+detect on the same edge while in SEARCH → `mode`=IDLE, not TRACK. Reserved IR 6 → no state change.
- **Async reset:** assert `rst_n`=0 mid-handshake, between edges → `cmd_valid`, `mode`, `cmd_dir` and `cmd_speed` go to 0 without a clock edge.
